// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave with a parametrised register file, byte-lane strobes and per-register write pulses.
// Build option: define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_regfile_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_WIDTH);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = RESP_OKAY;
`endif

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("axi4_lite_regfile_slave: DATA_WIDTH must be 32 or 64");
        end
        if (NUM_REGS < 2) begin : g_bad_regs
            $error("axi4_lite_regfile_slave: NUM_REGS must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_now;
    logic                  w_now;
    logic [IDX_WIDTH-1:0]  aw_idx;
    logic                  aw_in_range;
    logic [IDX_WIDTH-1:0]  ar_idx;
    logic                  ar_in_range;

    always_comb begin
        aw_hs       = awvalid && awready;
        w_hs        = wvalid && wready;
        aw_now      = aw_held || aw_hs;
        w_now       = w_held || w_hs;
        // Bits below LSB never reach the index; the range test still sees the whole address.
        aw_idx      = aw_addr_q[LSB +: IDX_WIDTH];
        aw_in_range = {1'b0, aw_addr_q} < ADDR_LIMIT;
        ar_idx      = araddr[LSB +: IDX_WIDTH];
        ar_in_range = {1'b0, araddr} < ADDR_LIMIT;
    end

    // Write path: AW and W are captured independently, then committed in WR_EXEC.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state     <= WR_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            // NOTE: the captured address/data/strobe need no reset; aw_held/w_held decide when they are valid.
        end else begin
            // NOTE: default first, then override below; the last non-blocking assignment in the block wins.
            reg_wr_pulse <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= awaddr;
                        aw_held   <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        w_held   <= 1'b1;
                    end
                    if (aw_now && w_now) begin
                        wr_state <= WR_EXEC;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                    end else begin
                        awready  <= !aw_now;
                        wready   <= !w_now;
                    end
                end
                WR_EXEC: begin
                    if (aw_in_range) begin
                        for (int b = 0; b < STRB_WIDTH; b++) begin
                            if (w_strb_q[b]) begin
                                regs[aw_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
                            end
                        end
                        reg_wr_pulse[aw_idx] <= 1'b1;
                        bresp                <= RESP_OKAY;
                    end else begin
                        bresp                <= RESP_OOR;
                    end
                    aw_held  <= 1'b0;
                    w_held   <= 1'b0;
                    bvalid   <= 1'b1;
                    wr_state <= WR_RESP;
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    wr_state <= WR_IDLE;
                    awready  <= 1'b0;
                    wready   <= 1'b0;
                    bvalid   <= 1'b0;
                end
            endcase
        end
    end

    // Read path samples regs before any same-edge commit, so it returns the pre-write value.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (arvalid && arready) begin
                        rdata    <= ar_in_range ? regs[ar_idx] : '0;
                        rresp    <= ar_in_range ? RESP_OKAY : RESP_OOR;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= RD_RESP;
                    end else begin
                        arready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                    arready  <= 1'b0;
                    rvalid   <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
        end
    endgenerate

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave (32-bit data, 16 registers) with a response scoreboard.
`timescale 1ns/1ps
module tb_axi4_lite_regfile_slave;

    localparam logic [31:0] RV = 32'h5A5A_0001;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [31:0]  awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr_pulse;

    always #5 aclk = ~aclk;

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .RESET_VAL  (RV)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [31:0] model [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_reg%0d", tag, i), 64'(reg_out[i*32 +: 32]), 64'(model[i]));
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input bit reset_in_resp);
        logic        in_range;
        logic [3:0]  idx;
        logic [15:0] one;
        logic [15:0] exp_pulse;
        logic [1:0]  exp_resp;
        bit          aw_done;
        bit          w_done;
        in_range  = addr < 32'h40;
        idx       = addr[5:2];
        one       = 16'h0001;
        exp_pulse = in_range ? (one << idx) : 16'h0000;
        bq.push_back(in_range ? 2'b00 : OOR);
        if (in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int k = 0; k < 64 && !(aw_done && w_done); k++) begin
            @(negedge aclk);
            if (aw_done && !w_done) check("wr_aw_blocked", 64'(awready), 64'd0);
            if (w_done && !aw_done) check("wr_w_blocked", 64'(wready), 64'd0);
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (k >= aw_delay);
            wvalid  = !w_done && (k >= w_delay);
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready) w_done = 1'b1;
        end
        check("wr_handshake_timeout", 64'(aw_done && w_done), 64'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_exec_bvalid", 64'(bvalid), 64'd0);
        check("wr_exec_ready", 64'({awready, wready}), 64'd0);
        @(negedge aclk);
        check("wr_bvalid_latency", 64'(bvalid), 64'd1);
        check("wr_pulse", 64'(reg_wr_pulse), 64'(exp_pulse));
        exp_resp = bq.pop_front();
        check("wr_bresp", 64'(bresp), 64'(exp_resp));
        check_regs("wr");
        if (reset_in_resp) begin
            aresetn = 1'b0;
            @(negedge aclk);
            for (int i = 0; i < 16; i++) model[i] = RV;
            check("rst_resp_bvalid", 64'(bvalid), 64'd0);
            check("rst_resp_ready", 64'({awready, wready, arready}), 64'd0);
            check_regs("rst_resp");
            aresetn = 1'b1;
            @(negedge aclk);
        end else begin
            @(negedge aclk);
            check("wr_pulse_one_cycle", 64'(reg_wr_pulse), 64'd0);
            check("wr_resp_hold", 64'({bvalid, bresp}), 64'({1'b1, exp_resp}));
            check("wr_resp_no_aw", 64'({awready, wready}), 64'd0);
            bready = 1'b1;
            @(negedge aclk);
            bready = 1'b0;
            check("wr_bvalid_clear", 64'(bvalid), 64'd0);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        logic        in_range;
        logic [3:0]  idx;
        logic [33:0] exp;
        bit          done;
        in_range = addr < 32'h40;
        idx      = addr[5:2];
        rq.push_back({in_range ? 2'b00 : OOR, in_range ? model[idx] : 32'h0});
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge aclk);
            araddr  = addr;
            arvalid = 1'b1;
            if (arready) done = 1'b1;
        end
        check("rd_ar_timeout", 64'(done), 64'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        check("rd_latency", 64'(rvalid), 64'd1);
        check("rd_arready_low", 64'(arready), 64'd0);
        exp = rq.pop_front();
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            check("rd_hold", 64'({rvalid, arready, rresp, rdata}), 64'({1'b1, 1'b0, exp}));
        end
        check("rd_rdata", 64'(rdata), 64'(exp[31:0]));
        check("rd_rresp", 64'(rresp), 64'(exp[33:32]));
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        check("rd_rvalid_clear", 64'(rvalid), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = RV;

        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        check("rst_ready", 64'({awready, wready, arready}), 64'd0);
        check("rst_valid", 64'({bvalid, rvalid}), 64'd0);
        check("rst_resp", 64'({bresp, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_pulse", 64'(reg_wr_pulse), 64'd0);
        check_regs("rst");
        aresetn = 1'b1;

        do_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 3, 1'b0);
        check("reg2_full", 64'(reg_out[2*32 +: 32]), 64'h0000_0000_DEAD_BEEF);

        do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0);
        do_write(32'h0C, 32'h1122_3344, 4'b0101, 0, 0, 1'b0);
        check("strb_merge", 64'(reg_out[3*32 +: 32]), 64'h0000_0000_FF22_FF44);

        do_write(32'h10, 32'h0BAD_F00D, 4'b1100, 2, 0, 1'b0);
        do_write(32'h14, 32'hCAFE_CAFE, 4'b0000, 1, 1, 1'b0);
        do_write(32'h3C, 32'h1357_9BDF, 4'hF, 0, 0, 1'b0);

        do_read(32'h08, 4);
        do_read(32'h0C, 0);
        do_read(32'h0B, 1);
        do_read(32'h14, 0);
        do_read(32'h3C, 0);

        do_write(32'h40, 32'hA5A5_A5A5, 4'hF, 0, 0, 1'b0);
        do_read(32'h40, 1);

        do_write(32'h08, 32'h1234_5678, 4'hF, 0, 0, 1'b1);
        do_read(32'h08, 0);

        check("sb_empty", 64'(bq.size() + rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
